load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 42 ++++
 rtl/load_store_unit_load_align.sv | 31 +++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared RV32I load/store definitions: data width, funct3 encodings, FSM states.
// No logic of its own; only constants, types and the legality helper.
// Imported by load_store_unit and load_align.
package load_store_unit_pkg;

    localparam int XLEN = 32;

    // funct3 encodings; stores reuse the low three load codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCESS    = 2'd1,
        ST_WRITEBACK = 2'd2
    } lsu_state_t;

    // True when funct3 is a defined encoding for the direction and the
    // address low bits satisfy its natural alignment.
    function automatic logic op_ok(input logic       is_store,
                                   input logic [2:0] f3,
                                   input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~addr_lo[0];
            F3_LW:   ok = (addr_lo == 2'b00);
            F3_LBU:  ok = ~is_store;
            F3_LHU:  ok = ~is_store & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data extraction: picks byte/half lane from the read word and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_align #(
    parameter int XLEN = load_store_unit_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);
    import load_store_unit_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane, then sign- or zero-extend by funct3
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one bus transaction per start, loads written back to the register file.
// Latency: request the cycle after start; load write_enable the cycle after mem_ack (min 3 cycles).
// Backpressure: busy stalls the pipeline outside IDLE; the bus request is held until mem_ack.
module load_store_unit #(
    parameter int XLEN = load_store_unit_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data,
    output logic            write_enable,
    output logic            fault
);
    import load_store_unit_pkg::*;

    lsu_state_t      state;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [4:0]      rd_q;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] load_result;

    // Store lane formatting from the incoming request (used only when latched in IDLE)
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (funct3)
            F3_SB: begin
                st_be    = 4'b0001 << address[1:0];
                st_wdata = {(XLEN/8){store_data[7:0]}};
            end
            F3_SH: begin
                st_be    = address[1] ? 4'b1100 : 4'b0011;
                st_wdata = {(XLEN/16){store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .result  (load_result)
    );

    // Transaction FSM; every output is a register updated here
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= 4'b0000;
            write_reg    <= 5'd0;
            write_data   <= '0;
            write_enable <= 1'b0;
            fault        <= 1'b0;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_lo_q    <= 2'b00;
            rd_q         <= 5'd0;
        end else begin
            fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op_ok(is_store, funct3, address[1:0])) begin
                            state      <= ST_ACCESS;
                            busy       <= 1'b1;
                            mem_req    <= 1'b1;
                            mem_we     <= is_store;
                            mem_addr   <= {address[XLEN-1:2], 2'b00};
                            mem_be     <= is_store ? st_be : 4'b0000;
                            mem_wdata  <= is_store ? st_wdata : '0;
                            is_store_q <= is_store;
                            funct3_q   <= funct3;
                            addr_lo_q  <= address[1:0];
                            rd_q       <= rd;
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_store_q) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state        <= ST_WRITEBACK;
                            write_reg    <= rd_q;
                            write_data   <= load_result;
                            write_enable <= (rd_q != 5'd0);
                        end
                    end
                end
                ST_WRITEBACK: begin
                    write_enable <= 1'b0;
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops vs. a byte-level model.
// Latency: drives inputs #1 after each rising edge and samples outputs at the same point.
// Backpressure: a bench-side bus responder inserts a chosen number of wait states before mem_ack.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        write_enable;
    logic        fault;

    int total = 0;
    int bad   = 0;

    load_store_unit dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .is_store     (is_store),
        .funct3       (funct3),
        .address      (address),
        .store_data   (store_data),
        .rd           (rd),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable),
        .fault        (fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Access size in bytes, 0 for an undefined encoding
    function automatic int op_size(input bit st, input int f3);
        if (st) return (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
        case (f3)
            0, 4:    return 1;
            1, 5:    return 2;
            2:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_legal(input bit st, input int f3, input logic [31:0] addr);
        int sz;
        sz = op_size(st, f3);
        if (sz == 0) return 0;
        return (addr % sz) == 0;
    endfunction

    function automatic logic [31:0] model_load(input int f3, input logic [31:0] addr, input logic [31:0] word);
        int    sz;
        int    off;
        longint v;
        longint span;
        sz   = op_size(0, f3);
        off  = addr % 4;
        span = longint'(1) << (8 * sz);
        v    = (longint'(word) >> (8 * off)) % span;
        if (f3 < 4 && sz < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(input int f3, input logic [31:0] addr);
        logic [3:0] be;
        int sz;
        int off;
        be  = 4'b0000;
        sz  = op_size(1, f3);
        off = addr % 4;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] sd);
        logic [31:0] w;
        int sz;
        w  = 32'h0;
        sz = op_size(1, f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] r, input int waits,
                         input logic [31:0] rdat, input bit intrude);
        is_store   = st;
        funct3     = f3;
        address    = addr;
        store_data = sd;
        rd         = r;
        start      = 1'b1;
        step();
        start      = 1'b0;
        address    = $urandom;
        store_data = $urandom;
        rd         = 5'($urandom);
        funct3     = 3'($urandom);
        if (!model_legal(st, int'(f3), addr)) begin
            check("fault_pulse", fault, 1);
            check("fault_no_req", mem_req, 0);
            check("fault_no_busy", busy, 0);
            step();
            check("fault_clear", fault, 0);
            check("fault_idle_busy", busy, 0);
            check("fault_idle_req", mem_req, 0);
            return;
        end
        check("req_fault", fault, 0);
        check("req_busy", busy, 1);
        check("req", mem_req, 1);
        check("req_we", mem_we, st);
        check("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("req_be", mem_be, st ? model_be(int'(f3), addr) : 4'b0000);
        if (st) check("req_wdata", mem_wdata, model_wdata(int'(f3), sd));
        for (int i = 0; i < waits; i++) begin
            if (intrude) begin
                start   = 1'b1;
                address = addr ^ 32'h40;
            end
            step();
            start = 1'b0;
            check("wait_req", mem_req, 1);
            check("wait_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check("wait_busy", busy, 1);
            check("wait_we_rf", write_enable, 0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdat;
        step();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        check("ack_req_drop", mem_req, 0);
        if (st) begin
            check("st_busy", busy, 0);
            check("st_no_wr", write_enable, 0);
            step();
            check("st_after_req", mem_req, 0);
            check("st_after_wr", write_enable, 0);
        end else begin
            check("ld_wr_en", write_enable, r != 5'd0);
            if (r != 5'd0) begin
                check("ld_wr_reg", write_reg, r);
                check("ld_wr_data", write_data, model_load(int'(f3), addr, rdat));
            end
            step();
            check("ld_wr_once", write_enable, 0);
            check("ld_busy_end", busy, 0);
            check("ld_no_req", mem_req, 0);
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        address    = 32'h0;
        store_data = 32'h0;
        rd         = 5'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_be", mem_be, 0);
        check("rst_wr_en", write_enable, 0);
        check("rst_wr_reg", write_reg, 0);
        check("rst_wr_data", write_data, 0);
        check("rst_fault", fault, 0);
        step();
        step();
        reset = 1'b1;

        // First start right after reset release; LW with two wait states
        do_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 2, 32'hDEADBEEF, 1'b0);
        // LB / LBU sign handling
        do_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 0, 32'h80112233, 1'b0);
        do_op(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 1, 32'h80112233, 1'b0);
        // SH upper half
        do_op(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd3, 1, 32'h0, 1'b0);
        // Misaligned LW
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd4, 0, 32'h0, 1'b0);
        // Load to x0 still accesses the bus
        do_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd0, 1, 32'h12345678, 1'b0);
        // Start during ACCESS must be ignored
        do_op(1'b0, 3'b001, 32'h402, 32'h0, 5'd9, 3, 32'hF00D8001, 1'b1);
        // Illegal store funct3
        do_op(1'b1, 3'b100, 32'h500, 32'h0, 5'd1, 0, 32'h0, 1'b0);

        // Reset while ACCESS is waiting for ack; the late ack must be ignored
        is_store = 1'b0;
        funct3   = 3'b010;
        address  = 32'h600;
        rd       = 5'd11;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("abort_req_before", mem_req, 1);
        step();
        #2;
        reset = 1'b0;
        #1;
        check("abort_req_async", mem_req, 0);
        check("abort_busy_async", busy, 0);
        step();
        reset = 1'b1;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        check("abort_no_wr", write_enable, 0);
        check("abort_no_req", mem_req, 0);
        check("abort_idle", busy, 0);
        step();
        check("abort_no_wr_late", write_enable, 0);

        // Randomized mix of legal and illegal loads and stores
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
